// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
//   MODE_EDGE / MODE_CENTER : counter mode encodings (MODE input, shadow/active mode)
//   DIR_UP / DIR_DOWN       : DIR output encodings
//   cnt_state_e             : counter/direction state machine states
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StUp,
    StDown
  } cnt_state_e;

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: duty compare against the shared counter, polarity and output register.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   en_i         : counter enable; when low the output parks at the inactive level (pol_i)
//   count_i      : shared period counter value for the current cycle
//   duty_i       : effective duty compare value for the current cycle
//   le_sel_i     : 1 = compare with <=, 0 = compare with <
//   pol_i        : 1 = inverted (active-low) output, applied live
//   pwm_o        : registered PWM output
module pwm_cmp_ch #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic             le_sel_i,
  input  logic             pol_i,
  output logic             pwm_o
);

  logic raw;
  logic pwm_d, pwm_q;

  always_comb begin
    raw   = le_sel_i ? (count_i <= duty_i) : (count_i < duty_i);
    pwm_d = en_i ? (raw ^ pol_i) : pol_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared edge- or center-aligned period counter.
//   CLK, RST    : clock, asynchronous active-high reset
//   EN          : counter enable; 0 holds the counter idle and outputs at POL
//   LOAD        : one-cycle strobe capturing MODE/PERIOD/DUTY into the shadow registers
//   MODE        : 0 = edge-aligned, 1 = center-aligned
//   PERIOD      : period value P
//   DUTY        : per-channel duty, channel i = DUTY[i*WIDTH +: WIDTH]
//   POL         : per-channel output inversion, applied live
//   PWM         : registered PWM outputs
//   CYCLE_START : registered pulse for the first cycle (count 0, going up) of each period
//   DIR         : registered counter direction (0 = up, 1 = down), same latency as PWM
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      LOAD,
  input  logic                      MODE,
  input  logic [WIDTH-1:0]          PERIOD,
  input  logic [CHANNELS*WIDTH-1:0] DUTY,
  input  logic [CHANNELS-1:0]       POL,
  output logic [CHANNELS-1:0]       PWM,
  output logic                      CYCLE_START,
  output logic                      DIR
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic                      shadow_mode_d, shadow_mode_q;
  logic [WIDTH-1:0]          shadow_period_d, shadow_period_q;
  logic [CHANNELS*WIDTH-1:0] shadow_duty_d, shadow_duty_q;
  logic                      active_mode_d, active_mode_q;
  logic [WIDTH-1:0]          active_period_d, active_period_q;
  logic [CHANNELS*WIDTH-1:0] active_duty_d, active_duty_q;
  logic                      load_pend_d, load_pend_q;
  logic [WIDTH-1:0]          count_d, count_q;
  cnt_state_e                state_d, state_q;
  logic                      dir_d, dir_q;
  logic                      cycle_start_d, cycle_start_q;

  logic                      boundary;
  logic                      xfer;
  logic                      eff_mode;
  logic [WIDTH-1:0]          eff_period;
  logic [CHANNELS*WIDTH-1:0] eff_duty;
  logic                      le_sel;

  always_comb begin
    boundary = (count_q == '0) && (state_q != StDown);
    // While idle the counter is parked, so pending values move across every cycle.
    xfer     = load_pend_q && (boundary || !EN);

    // The boundary cycle itself already runs on the values being transferred, so the
    // whole new period (including its count-0 cycle) uses one consistent setting.
    eff_mode   = xfer ? shadow_mode_q   : active_mode_q;
    eff_period = xfer ? shadow_period_q : active_period_q;
    eff_duty   = xfer ? shadow_duty_q   : active_duty_q;

    active_mode_d   = eff_mode;
    active_period_d = eff_period;
    active_duty_d   = eff_duty;

    shadow_mode_d   = LOAD ? MODE   : shadow_mode_q;
    shadow_period_d = LOAD ? PERIOD : shadow_period_q;
    shadow_duty_d   = LOAD ? DUTY   : shadow_duty_q;
    // A LOAD coinciding with a transfer re-arms the pending flag for the new values.
    load_pend_d     = LOAD || (load_pend_q && !xfer);

    count_d = '0;
    state_d = StIdle;
    if (EN) begin
      if (eff_period == '0) begin
        count_d = '0;
        state_d = StUp;
      end else if (eff_mode == MODE_EDGE) begin
        count_d = (count_q >= eff_period) ? '0 : count_q + One;
        state_d = StUp;
      end else if (state_q == StDown) begin
        if (count_q <= One) begin
          count_d = '0;
          state_d = StUp;
        end else begin
          count_d = count_q - One;
          state_d = StDown;
        end
      end else if (count_q >= eff_period) begin
        // Peak reached: turn around. With P = 1 the down leg is empty.
        count_d = eff_period - One;
        state_d = (eff_period == One) ? StUp : StDown;
      end else begin
        count_d = count_q + One;
        state_d = StUp;
      end
    end

    // Center mode compares with <= on the down leg and at the peak; including the peak
    // keeps high time at 2*D so that D = P gives a full period.
    le_sel = (eff_mode == MODE_CENTER) && (eff_period != '0) &&
             ((state_q == StDown) || (count_q == eff_period));

    cycle_start_d = EN && boundary;
    dir_d         = (EN && (state_q == StDown)) ? DIR_DOWN : DIR_UP;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow_mode_q   <= MODE_EDGE;
      shadow_period_q <= '0;
      shadow_duty_q   <= '0;
      active_mode_q   <= MODE_EDGE;
      active_period_q <= '0;
      active_duty_q   <= '0;
      load_pend_q     <= 1'b0;
      count_q         <= '0;
      state_q         <= StIdle;
      dir_q           <= DIR_UP;
      cycle_start_q   <= 1'b0;
    end else begin
      shadow_mode_q   <= shadow_mode_d;
      shadow_period_q <= shadow_period_d;
      shadow_duty_q   <= shadow_duty_d;
      active_mode_q   <= active_mode_d;
      active_period_q <= active_period_d;
      active_duty_q   <= active_duty_d;
      load_pend_q     <= load_pend_d;
      count_q         <= count_d;
      state_q         <= state_d;
      dir_q           <= dir_d;
      cycle_start_q   <= cycle_start_d;
    end
  end

  genvar i;
  for (i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_cmp_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i   (CLK),
      .rst_i   (RST),
      .en_i    (EN),
      .count_i (count_q),
      .duty_i  (eff_duty[i*WIDTH +: WIDTH]),
      .le_sel_i(le_sel),
      .pol_i   (POL[i]),
      .pwm_o   (PWM[i])
    );
  end

  assign CYCLE_START = cycle_start_q;
  assign DIR         = dir_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus phases push hand-written expected waveforms
// (one entry per cycle, '-' = don't care) and a negedge monitor pops and compares them.
module tb_pwm_multi;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic        LOAD;
  logic        MODE;
  logic [7:0]  PERIOD;
  logic [31:0] DUTY;
  logic [3:0]  POL;
  logic [3:0]  PWM;
  logic        CYCLE_START;
  logic        DIR;

  pwm_multi #(
    .WIDTH   (8),
    .CHANNELS(4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .LOAD       (LOAD),
    .MODE       (MODE),
    .PERIOD     (PERIOD),
    .DUTY       (DUTY),
    .POL        (POL),
    .PWM        (PWM),
    .CYCLE_START(CYCLE_START),
    .DIR        (DIR)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] pwm;
    logic [3:0] pm;
    logic       cs;
    logic       csm;
    logic       dir;
    logic       dm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: outputs are sampled on the falling edge, after the edge indexed by cyc.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || ((PWM & e.pm) !== (e.pwm & e.pm)) ||
          (e.csm && (CYCLE_START !== e.cs)) || (e.dm && (DIR !== e.dir))) begin
        failures++;
        $display("FAIL %s cyc=%0d(exp cyc %0d): got pwm=%b cs=%b dir=%b, want pwm=%b mask=%b cs=%b dir=%b",
                 e.name, cyc, e.cyc, PWM, CYCLE_START, DIR, e.pwm, e.pm, e.cs, e.dir);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic string rep(input string s, input int n);
    string r = "";
    for (int k = 0; k < n; k++) r = {r, s};
    return r;
  endfunction

  // Waveform strings: character j describes the outputs observed after edge c0 + j.
  task automatic push_wave(input string name, input int c0, input string w0, input string w1,
                           input string w2, input string w3, input string wcs, input string wdir);
    exp_t x;
    string w[4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int j = 0; j < wcs.len(); j++) begin
      x.cyc  = c0 + j;
      x.name = name;
      for (int ch = 0; ch < 4; ch++) begin
        x.pwm[ch] = (w[ch][j] == "1");
        x.pm[ch]  = (w[ch][j] != "-");
      end
      x.cs  = (wcs[j] == "1");
      x.csm = (wcs[j] != "-");
      x.dir = (wdir[j] == "1");
      x.dm  = (wdir[j] != "-");
      sb.push_back(x);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Present a LOAD so that it is sampled by edge x.
  task automatic load_at(input int x, input logic m, input logic [7:0] p, input logic [31:0] d);
    wait_cyc(x - 1);
    MODE   = m;
    PERIOD = p;
    DUTY   = d;
    LOAD   = 1'b1;
    wait_cyc(x);
    LOAD   = 1'b0;
  endtask

  localparam logic [31:0] DutyBase = {8'd5, 8'd10, 8'd0, 8'd3};

  initial begin
    RST = 1'b1; EN = 1'b0; LOAD = 1'b0; MODE = 1'b0; PERIOD = '0; DUTY = '0; POL = '0;
    push_wave("reset", 1, "00", "00", "00", "00", "00", "00");
    wait_cyc(2);
    RST = 1'b0;

    // Edge mode P=9, duties 3/0/10/5, then glitch-free duty updates on channel 0.
    push_wave("idle_pre", 3, "00", "00", "00", "00", "00", "00");
    push_wave("edge_d3", 5, rep("1110000000", 3), rep("0", 30), rep("1", 30),
              rep("1111100000", 3), rep("1000000000", 3), rep("0", 30));
    push_wave("upd_d7", 35, rep("1111111000", 2), rep("0", 20), rep("1", 20),
              rep("1111100000", 2), rep("1000000000", 2), rep("0", 20));
    push_wave("upd_last_wins", 55, "1111000000", rep("0", 10), rep("1", 10),
              "1111100000", "1000000000", rep("0", 10));
    push_wave("upd_on_boundary", 65, "1111110000", rep("0", 10), rep("1", 10),
              "1111100000", "1000000000", rep("0", 10));
    load_at(4, 1'b0, 8'd9, DutyBase);
    EN = 1'b1;
    load_at(28, 1'b0, 8'd9, {DutyBase[31:8], 8'd7});  // mid-period
    load_at(45, 1'b0, 8'd9, {DutyBase[31:8], 8'd2});  // on boundary, nothing pending
    load_at(50, 1'b0, 8'd9, {DutyBase[31:8], 8'd4});  // overwrites the 2
    load_at(55, 1'b0, 8'd9, {DutyBase[31:8], 8'd6});  // on boundary with 4 pending
    load_at(70, 1'b0, 8'd9, DutyBase);

    // Polarity on channel 0, then EN low mid-period and back high.
    push_wave("pol_inv", 75, "00011", "00000", "11111", "11111", "10000", "00000");
    push_wave("en_off", 80, "11111", "00000", "00000", "00000", "00000", "00000");
    wait_cyc(74);
    POL = 4'b0001;
    wait_cyc(79);
    EN = 1'b0;
    push_wave("en_restart", 85, "0001111111", rep("0", 10), rep("1", 10),
              "1111100000", "1000000000", rep("0", 10));
    wait_cyc(84);
    EN = 1'b1;

    // Center mode P=4, duties 1/2/4/0.
    push_wave("center", 95, rep("10000001", 2), rep("11000011", 2), rep("1", 16), rep("0", 16),
              rep("10000000", 2), rep("00000111", 2));
    load_at(90, 1'b1, 8'd4, {8'd0, 8'd4, 8'd2, 8'd1});
    wait_cyc(94);
    POL = 4'b0000;

    // P=0: every cycle is a boundary, outputs follow D != 0.
    push_wave("p_zero", 111, "0000", "1111", "0000", "1111", "1111", "0000");
    push_wave("async_rst", 115, "0", "0", "0", "0", "0", "0");
    load_at(105, 1'b0, 8'd0, {8'd255, 8'd0, 8'd1, 8'd0});

    // LOAD then asynchronous reset between edges: the pending load is lost.
    load_at(115, 1'b0, 8'd9, DutyBase);
    #2;
    RST = 1'b1;
    push_wave("rst_hold", 116, rep("0", 7), rep("0", 7), rep("0", 7), rep("0", 7),
              rep("-", 7), rep("0", 7));
    wait_cyc(116);
    RST = 1'b0;
    push_wave("reload", 123, "1110000000", rep("0", 10), rep("1", 10),
              "1111100000", "1000000000", rep("0", 10));
    load_at(122, 1'b0, 8'd9, DutyBase);

    wait_cyc(134);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
